// File: rtl/mem_if_pkg.sv
// Shared encodings for the core_v6 memory responder: bus op codes, funct3
// access widths, the reset NOP and the responder state encoding.
package mem_if_pkg;

   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_LOAD  = 2'b01,
      OP_STORE = 2'b10,
      OP_RSVD  = 2'b11
   } op_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_FETCH = 2'b00,
      ST_DREQ  = 2'b01,
      ST_DWAIT = 2'b10,
      ST_DRESP = 2'b11
   } state_e;

   // Reserved op code 11 behaves like NONE.
   function automatic logic is_access(input logic [1:0] op);
      return (op == OP_LOAD) || (op == OP_STORE);
   endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for one data access: store byte enables and replicated
// write data, load extraction with sign/zero extension, and alignment errors.
module mem_lane_align
   import mem_if_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [1:0]   addr_lo_i,
   input  logic [2:0]   width_i,
   input  logic [W-1:0] wdata_i,
   input  logic [W-1:0] rdata_i,
   output logic [3:0]   be_o,
   output logic [W-1:0] wdata_rep_o,
   output logic [W-1:0] rdata_ext_o,
   output logic         err_o
);

   logic [W-1:0] shifted;

   // NOTE: every output is given a default first so no path through the case infers a latch.
   always_comb begin
      shifted     = rdata_i >> {addr_lo_i, 3'b000};
      be_o        = 4'b0000;
      wdata_rep_o = wdata_i;
      rdata_ext_o = '0;
      err_o       = 1'b0;
      case (width_i)
         F3_B, F3_BU: begin
            be_o        = 4'b0001 << addr_lo_i;
            wdata_rep_o = {(W/8){wdata_i[7:0]}};
            rdata_ext_o = (width_i == F3_B) ? {{(W-8){shifted[7]}}, shifted[7:0]}
                                            : {{(W-8){1'b0}}, shifted[7:0]};
         end
         F3_H, F3_HU: begin
            err_o       = addr_lo_i[0];
            be_o        = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wdata_rep_o = {(W/16){wdata_i[15:0]}};
            rdata_ext_o = (width_i == F3_H) ? {{(W-16){shifted[15]}}, shifted[15:0]}
                                            : {{(W-16){1'b0}}, shifted[15:0]};
         end
         F3_W: begin
            err_o       = (addr_lo_i != 2'b00);
            be_o        = 4'b1111;
            rdata_ext_o = shifted;
         end
         default: err_o = 1'b1;
      endcase
      if (err_o) be_o = 4'b0000;
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for core_v6: zero-wait instruction fetch from a single-ported
// synchronous RAM, with data accesses stalling the core for WAIT_STATES+2 cycles.
module mem_responder
   import mem_if_pkg::*;
#(
   parameter int W           = 32,
   parameter int ADDR_BITS   = 12,
   parameter int WAIT_STATES = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [W-1:0]         inst_addr,
   output logic [W-1:0]         inst_rdata,
   input  logic [W-1:0]         data_addr,
   input  logic [W-1:0]         data_wdata,
   input  logic [1:0]           opType,
   input  logic [2:0]           width,
   output logic                 mem_stall,
   output logic [W-1:0]         data_rdata,
   output logic                 bus_err,
   output logic                 ram_en,
   output logic                 ram_we,
   output logic [3:0]           ram_be,
   output logic [ADDR_BITS-1:0] ram_addr,
   output logic [W-1:0]         ram_wdata,
   input  logic [W-1:0]         ram_rdata
);

   state_e         state_q, state_d, cur_state;
   logic [3:0]     wait_cnt_q, wait_cnt_d;
   logic           served_q, served_d;
   logic           is_load_q, is_load_d;
   logic [1:0]     addr_lo_q, addr_lo_d;
   logic [2:0]     width_q, width_d;
   logic           err_q, err_d;
   logic           ifetch_vld_q, ifetch_vld_d;
   logic [W-1:0]   inst_hold_q, inst_hold_d;
   logic [W-1:0]   data_rdata_q, data_rdata_d;

   logic           accept;
   logic           range_err;
   logic [1:0]     lane_addr_lo;
   logic [2:0]     lane_width;
   logic [3:0]     lane_be;
   logic [W-1:0]   lane_wdata;
   logic [W-1:0]   lane_rdata;
   logic           lane_err;

   logic                 stall_c, bus_err_c, ram_en_c, ram_we_c;
   logic [3:0]           ram_be_c;
   logic [ADDR_BITS-1:0] ram_addr_c;

   logic unused_addr_bits;
   assign unused_addr_bits = ^{inst_addr[W-1:ADDR_BITS+2], inst_addr[1:0]};

   // The accept cycle is itself the DREQ cycle, so DREQ only ever exists combinationally.
   assign accept    = (state_q == ST_FETCH) && !served_q && is_access(opType);
   assign cur_state = accept ? ST_DREQ : state_q;
   assign range_err = |data_addr[W-1:ADDR_BITS+2];

   assign lane_addr_lo = (cur_state == ST_DREQ) ? data_addr[1:0] : addr_lo_q;
   assign lane_width   = (cur_state == ST_DREQ) ? width          : width_q;

   mem_lane_align #(
      .W (W)
   ) u_lane (
      .addr_lo_i   (lane_addr_lo),
      .width_i     (lane_width),
      .wdata_i     (data_wdata),
      .rdata_i     (ram_rdata),
      .be_o        (lane_be),
      .wdata_rep_o (lane_wdata),
      .rdata_ext_o (lane_rdata),
      .err_o       (lane_err)
   );

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      served_d     = served_q;
      is_load_d    = is_load_q;
      addr_lo_d    = addr_lo_q;
      width_d      = width_q;
      err_d        = err_q;
      ifetch_vld_d = 1'b0;
      inst_hold_d  = inst_rdata;
      data_rdata_d = data_rdata_q;
      stall_c      = 1'b0;
      bus_err_c    = 1'b0;
      ram_en_c     = 1'b0;
      ram_we_c     = 1'b0;
      ram_be_c     = 4'b0000;
      ram_addr_c   = inst_addr[ADDR_BITS+1:2];

      case (cur_state)
         ST_FETCH: begin
            ram_en_c     = 1'b1;
            ifetch_vld_d = 1'b1;
            served_d     = 1'b0;
         end
         ST_DREQ: begin
            stall_c    = 1'b1;
            ram_en_c   = 1'b1;
            ram_addr_c = data_addr[ADDR_BITS+1:2];
            is_load_d  = (opType == OP_LOAD);
            addr_lo_d  = data_addr[1:0];
            width_d    = width;
            err_d      = lane_err || range_err;
            if ((opType == OP_STORE) && !(lane_err || range_err)) begin
               ram_we_c = 1'b1;
               ram_be_c = lane_be;
            end
            if (WAIT_STATES == 0) begin
               state_d = ST_DRESP;
            end else begin
               state_d    = ST_DWAIT;
               wait_cnt_d = 4'(WAIT_STATES - 1);
            end
         end
         ST_DWAIT: begin
            stall_c = 1'b1;
            if (wait_cnt_q == 4'd0) state_d = ST_DRESP;
            else                    wait_cnt_d = wait_cnt_q - 4'd1;
         end
         ST_DRESP: begin
            // Re-read the fetch address so inst_rdata is valid again on release.
            stall_c      = 1'b1;
            bus_err_c    = err_q;
            ram_en_c     = 1'b1;
            ifetch_vld_d = 1'b1;
            served_d     = 1'b1;
            state_d      = ST_FETCH;
            if (is_load_q) data_rdata_d = err_q ? '0 : lane_rdata;
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_FETCH;
         wait_cnt_q   <= '0;
         served_q     <= 1'b0;
         is_load_q    <= 1'b0;
         addr_lo_q    <= '0;
         width_q      <= '0;
         err_q        <= 1'b0;
         ifetch_vld_q <= 1'b0;
         inst_hold_q  <= W'(NOP_INSN);
         data_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         served_q     <= served_d;
         is_load_q    <= is_load_d;
         addr_lo_q    <= addr_lo_d;
         width_q      <= width_d;
         err_q        <= err_d;
         ifetch_vld_q <= ifetch_vld_d;
         inst_hold_q  <= inst_hold_d;
         data_rdata_q <= data_rdata_d;
      end
   end

   // Fresh RAM data is forwarded the cycle after a fetch read; otherwise the last word is held.
   assign inst_rdata = ifetch_vld_q ? ram_rdata : inst_hold_q;
   assign data_rdata = data_rdata_q;
   assign mem_stall  = !reset && stall_c;
   assign bus_err    = !reset && bus_err_c;
   assign ram_en     = !reset && ram_en_c;
   assign ram_we     = !reset && ram_we_c;
   assign ram_be     = reset ? 4'b0000 : ram_be_c;
   assign ram_addr   = ram_addr_c;
   assign ram_wdata  = lane_wdata;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, reset corner cases and
// randomized accesses against a byte-level memory model.
module tb_mem_responder;
   import mem_if_pkg::*;

   localparam int         WS    = 2;
   localparam int         AB    = 12;
   localparam int         IWORD = 'h40;
   localparam logic [1:0] LD    = 2'b01;
   localparam logic [1:0] ST    = 2'b10;

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
   logic [1:0]    opType;
   logic [2:0]    width;
   logic          mem_stall, bus_err, ram_en, ram_we;
   logic [3:0]    ram_be;
   logic [AB-1:0] ram_addr;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata = 32'h0;

   always #5 clk = ~clk;

   mem_responder #(.W(32), .ADDR_BITS(AB), .WAIT_STATES(WS)) dut (
      .clk        (clk),
      .reset      (reset),
      .inst_addr  (inst_addr),
      .inst_rdata (inst_rdata),
      .data_addr  (data_addr),
      .data_wdata (data_wdata),
      .opType     (opType),
      .width      (width),
      .mem_stall  (mem_stall),
      .data_rdata (data_rdata),
      .bus_err    (bus_err),
      .ram_en     (ram_en),
      .ram_we     (ram_we),
      .ram_be     (ram_be),
      .ram_addr   (ram_addr),
      .ram_wdata  (ram_wdata),
      .ram_rdata  (ram_rdata)
   );

   // Synchronous RAM macro: output register holds while not enabled.
   logic [31:0] ram [4096];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we)
            for (int b = 0; b < 4; b++)
               if (ram_be[b]) ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
         ram_rdata <= ram[ram_addr];
      end
   end

   logic [31:0] model_mem [4096];
   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model ----------------
   function automatic int size_of(input logic [2:0] wd);
      case (wd[1:0])
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic model_err(input logic [31:0] a, input logic [2:0] wd);
      if (wd == 3'b011 || wd == 3'b110 || wd == 3'b111) return 1'b1;
      if (a >= 32'h0000_4000) return 1'b1;
      return (a % size_of(wd)) != 0;
   endfunction

   function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] wd);
      int sz = size_of(wd);
      logic [31:0] word = model_mem[a[13:2]];
      logic [31:0] mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*sz)) - 32'd1);
      logic [31:0] v = (word >> (8 * (a % 4))) & mask;
      if (!wd[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
      return v;
   endfunction

   function automatic logic [3:0] model_be(input logic [31:0] a, input logic [2:0] wd);
      logic [3:0] m = 4'((1 << size_of(wd)) - 1);
      return 4'(m << (a % 4));
   endfunction

   function automatic logic [31:0] model_rep(input logic [31:0] d, input logic [2:0] wd);
      case (size_of(wd))
         1:       return {4{d[7:0]}};
         2:       return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   task automatic model_store(input logic [31:0] a, input logic [2:0] wd, input logic [31:0] d);
      int k = a % 4;
      for (int j = 0; j < size_of(wd); j++)
         model_mem[a[13:2]][8*(k+j) +: 8] = d[8*j +: 8];
   endtask

   // ---------------- access driver ----------------
   // Call just after a rising edge; returns just after the release edge with opType = NONE.
   task automatic do_access(input logic [1:0] op, input logic [31:0] a, input logic [2:0] wd,
                            input logic [31:0] wdat, output int n_stall, output int n_err,
                            output int err_pos, output int n_den, output int n_we,
                            output logic [3:0] be_s, output logic [31:0] wd_s,
                            output logic [31:0] rd_s, output logic [31:0] inst_s);
      n_stall = 0; n_err = 0; err_pos = -1; n_den = 0; n_we = 0;
      be_s = '0; wd_s = '0;
      opType = op; data_addr = a; width = wd; data_wdata = wdat;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus_err) begin
            n_err++;
            err_pos = mem_stall ? n_stall + 1 : -2;
         end
         if (ram_en && ram_addr == a[13:2]) n_den++;
         if (ram_we) begin
            n_we++;
            be_s = ram_be;
            wd_s = ram_wdata;
         end
         if (!mem_stall) break;
         n_stall++;
      end
      rd_s   = data_rdata;
      inst_s = inst_rdata;
      tick();
      opType = 2'b00;
   endtask

   task automatic run_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                            input logic [2:0] wd, input logic [31:0] wdat,
                            input logic [31:0] rd_exp, input logic err_exp,
                            input logic [3:0] be_exp, input logic [31:0] wrep_exp);
      int n_stall, n_err, err_pos, n_den, n_we;
      logic [3:0] be_s;
      logic [31:0] wd_s, rd_s, inst_s;
      logic do_write;
      do_write = (op == ST) && !err_exp;
      do_access(op, a, wd, wdat, n_stall, n_err, err_pos, n_den, n_we, be_s, wd_s, rd_s, inst_s);
      check({tag, " stall_len"}, n_stall, WS + 2);
      check({tag, " bus_err_cnt"}, n_err, {31'd0, err_exp});
      if (err_exp) check({tag, " bus_err_pos"}, err_pos, WS + 2);
      check({tag, " data_ram_en"}, n_den, 1);
      check({tag, " we_cnt"}, n_we, {31'd0, do_write});
      if (do_write) begin
         check({tag, " ram_be"}, {28'd0, be_s}, {28'd0, be_exp});
         check({tag, " ram_wdata"}, wd_s, wrep_exp);
      end
      check({tag, " data_rdata"}, rd_s, rd_exp);
      check({tag, " inst_restore"}, inst_s, model_mem[IWORD]);
   endtask

   typedef struct packed {
      logic [1:0]  op;
      logic [31:0] addr;
      logic [2:0]  wd;
      logic [31:0] wdata;
      logic [31:0] rd;
      logic        err;
      logic [3:0]  be;
      logic [31:0] wrep;
   } vec_t;

   vec_t vecs [21];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] prev_rd;
      int n_we;

      vecs[0]  = '{LD, 32'h10,    F3_W,   32'h0,        32'hDEADBEEF, 1'b0, 4'h0, 32'h0};
      vecs[1]  = '{LD, 32'h13,    F3_B,   32'h0,        32'hFFFFFFDE, 1'b0, 4'h0, 32'h0};
      vecs[2]  = '{LD, 32'h13,    F3_BU,  32'h0,        32'h000000DE, 1'b0, 4'h0, 32'h0};
      vecs[3]  = '{LD, 32'h12,    F3_H,   32'h0,        32'hFFFFDEAD, 1'b0, 4'h0, 32'h0};
      vecs[4]  = '{LD, 32'h10,    F3_HU,  32'h0,        32'h0000BEEF, 1'b0, 4'h0, 32'h0};
      vecs[5]  = '{ST, 32'h11,    F3_B,   32'h000000A5, 32'h0000BEEF, 1'b0, 4'b0010, 32'hA5A5A5A5};
      vecs[6]  = '{LD, 32'h10,    F3_W,   32'h0,        32'hDEADA5EF, 1'b0, 4'h0, 32'h0};
      vecs[7]  = '{ST, 32'h10,    F3_W,   32'h12345678, 32'hDEADA5EF, 1'b0, 4'b1111, 32'h12345678};
      vecs[8]  = '{LD, 32'h10,    F3_W,   32'h0,        32'h12345678, 1'b0, 4'h0, 32'h0};
      vecs[9]  = '{ST, 32'h13,    F3_H,   32'h0000FFFF, 32'h12345678, 1'b1, 4'h0, 32'h0};
      vecs[10] = '{LD, 32'h12,    F3_W,   32'h0,        32'h00000000, 1'b1, 4'h0, 32'h0};
      vecs[11] = '{LD, 32'h10,    F3_W,   32'h0,        32'h12345678, 1'b0, 4'h0, 32'h0};
      vecs[12] = '{LD, 32'h3,     3'b011, 32'h0,        32'h00000000, 1'b1, 4'h0, 32'h0};
      vecs[13] = '{LD, 32'h10000, F3_W,   32'h0,        32'h00000000, 1'b1, 4'h0, 32'h0};
      vecs[14] = '{ST, 32'h12,    F3_H,   32'h0000CAFE, 32'h00000000, 1'b0, 4'b1100, 32'hCAFECAFE};
      vecs[15] = '{LD, 32'h10,    F3_W,   32'h0,        32'hCAFE5678, 1'b0, 4'h0, 32'h0};
      vecs[16] = '{LD, 32'h10,    F3_B,   32'h0,        32'h00000078, 1'b0, 4'h0, 32'h0};
      vecs[17] = '{LD, 32'h12,    F3_H,   32'h0,        32'hFFFFCAFE, 1'b0, 4'h0, 32'h0};
      vecs[18] = '{LD, 32'h12,    F3_HU,  32'h0,        32'h0000CAFE, 1'b0, 4'h0, 32'h0};
      vecs[19] = '{ST, 32'h13,    F3_B,   32'h00000080, 32'h0000CAFE, 1'b0, 4'b1000, 32'h80808080};
      vecs[20] = '{LD, 32'h13,    F3_B,   32'h0,        32'hFFFFFF80, 1'b0, 4'h0, 32'h0};

      for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
      ram[0] = 32'hA0A0_0001;
      ram[1] = 32'hB0B0_0002;
      ram[2] = 32'hC0C0_0003;
      ram[4] = 32'hDEAD_BEEF;
      ram[IWORD] = 32'h0050_0093;
      for (int i = 'h80; i < 'h90; i++) ram[i] = $urandom;
      for (int i = 0; i < 4096; i++) model_mem[i] = ram[i];

      reset = 1'b1; inst_addr = 32'h0; opType = 2'b00;
      data_addr = 32'h0; data_wdata = 32'h0; width = F3_W;

      // Reset held two cycles.
      repeat (2) @(negedge clk);
      check("reset inst_rdata", inst_rdata, 32'h0000_0013);
      check("reset mem_stall", {31'd0, mem_stall}, 32'd0);
      check("reset data_rdata", data_rdata, 32'd0);
      check("reset bus_err", {31'd0, bus_err}, 32'd0);
      check("reset ram_en", {31'd0, ram_en}, 32'd0);
      reset = 1'b0;
      #1;
      check("post-reset inst_rdata", inst_rdata, 32'h0000_0013);

      // Zero-wait fetch: each word appears one cycle after its address.
      for (int i = 0; i < 3; i++) begin
         inst_addr = 32'(4 * i);
         @(negedge clk);
         check($sformatf("fetch%0d inst_rdata", i), inst_rdata, model_mem[i]);
         check($sformatf("fetch%0d no stall", i), {31'd0, mem_stall}, 32'd0);
      end
      inst_addr = 32'(IWORD * 4);
      tick();
      tick();

      // Directed table, issued back to back.
      for (int i = 0; i < 21; i++) begin
         run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].addr, vecs[i].wd, vecs[i].wdata,
                   vecs[i].rd, vecs[i].err, vecs[i].be, vecs[i].wrep);
         if (vecs[i].op == ST && !vecs[i].err) model_store(vecs[i].addr, vecs[i].wd, vecs[i].wdata);
      end
      check("table mem word4", ram[4], 32'h80FE5678);

      // Reset arriving while the load sits in a wait state.
      n_we = 0;
      opType = LD; data_addr = 32'h10; width = F3_W;
      @(negedge clk);
      check("rst-mid stall dreq", {31'd0, mem_stall}, 32'd1);
      @(negedge clk);
      check("rst-mid stall dwait", {31'd0, mem_stall}, 32'd1);
      reset = 1'b1; opType = 2'b00;
      @(negedge clk);
      if (ram_we) n_we++;
      check("rst-mid stall in reset", {31'd0, mem_stall}, 32'd0);
      check("rst-mid data_rdata", data_rdata, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      if (ram_we) n_we++;
      check("rst-mid fetch no stall", {31'd0, mem_stall}, 32'd0);
      check("rst-mid bus_err", {31'd0, bus_err}, 32'd0);
      check("rst-mid data_rdata after", data_rdata, 32'd0);
      check("rst-mid no write", n_we, 0);
      check("rst-mid mem intact", ram[4], model_mem[4]);
      tick();
      prev_rd = 32'd0;

      // Randomized accesses against the model.
      for (int i = 0; i < 80; i++) begin
         logic [1:0]  op;
         logic [31:0] a, d, rd_exp;
         logic [2:0]  wd;
         logic        e;
         op = 2'($urandom_range(0, 3));
         a  = ($urandom_range(0, 7) == 0) ? 32'h4000 + $urandom_range(0, 255)
                                          : 32'h200 + $urandom_range(0, 63);
         wd = 3'($urandom_range(0, 7));
         d  = $urandom;
         if (is_access(op)) begin
            e = model_err(a, wd);
            rd_exp = (op == LD) ? (e ? 32'd0 : model_load(a, wd)) : prev_rd;
            run_check($sformatf("rnd%0d", i), op, a, wd, d, rd_exp, e, model_be(a, wd),
                      model_rep(d, wd));
            if (op == ST && !e) model_store(a, wd, d);
            prev_rd = rd_exp;
         end else begin
            opType = op; data_addr = a; width = wd; data_wdata = d;
            @(negedge clk);
            check($sformatf("rnd%0d idle no stall", i), {31'd0, mem_stall}, 32'd0);
            tick();
            opType = 2'b00;
         end
      end
      for (int i = 'h80; i < 'h90; i++)
         check($sformatf("final mem[%0h]", i), ram[i], model_mem[i]);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
